digit_entry_packer: RTL and testbench

- Keypad-side writer for the 32-bit packed BCD digit word that the seven-segment digit-select path reads 4 bits at a time.
- Shifts entered decimal digits into the ones position, supports backspace, clear and commit, and tracks the digit count.
- Holds a committed value for the ATM control FSM, e.g. a PIN or an amount.
- Sits between the debounced button/keypad decoder and the display/transaction logic.

---
 rtl/digit_entry_packer.sv | 145 ++++++++++++++
 tb/tb_digit_entry_packer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/digit_entry_packer.sv
// digit_entry_packer: keypad-side BCD digit buffer.
// Shifts entered digits into the ones nibble, with backspace, clear and commit.
// A commit latches the buffer into value_out and locks the buffer until clear.
// Build option: define DIGIT_MASK_EN to add a 'mask' input that shows entered
// display positions as the dash code 4'hA.

// One display nibble: blank, dash or the digit itself.
module digit_disp_lane #(
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic [3:0] digit,
    input  logic       entered,
    input  logic       mask,
    output logic [3:0] disp
);
    assign disp = !entered ? BLANK_CODE : (mask ? 4'hA : digit);
endmodule

module digit_entry_packer #(
    parameter int         MAX_DIGITS = 8,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        digit_valid,
    input  logic [3:0]  digit_in,
    input  logic        backspace,
    input  logic        clear,
    input  logic        commit,
`ifdef DIGIT_MASK_EN
    input  logic        mask,
`endif
    output logic [31:0] data_out,
    output logic [31:0] disp_out,
    output logic [3:0]  count,
    output logic        full,
    output logic        empty,
    output logic        locked,
    output logic [31:0] value_out,
    output logic        commit_valid,
    output logic        err
);
    localparam int         NUM_LANES = 8;
    localparam logic [3:0] MAXC      = 4'(MAX_DIGITS);

    // Nibbles at or above MAX_DIGITS must never hold a digit.
    function automatic logic [31:0] keep_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (i < MAX_DIGITS) m[4*i +: 4] = 4'hF;
        return m;
    endfunction
    localparam logic [31:0] KEEP = keep_mask();

    typedef enum logic {ENTRY, LOCKED} state_t;
    state_t state, state_nx;

    logic [31:0] data_nx, value_nx;
    logic [3:0]  cnt_nx;
    logic        cv_nx, err_nx, mask_w;
    logic [NUM_LANES-1:0][3:0] disp_nx;

`ifdef DIGIT_MASK_EN
    assign mask_w = mask;
`else
    assign mask_w = 1'b0;
`endif

    // Strobe arbitration: clear > commit > backspace > digit_valid.
    always_comb begin
        data_nx  = data_out;
        cnt_nx   = count;
        state_nx = state;
        value_nx = value_out;
        cv_nx    = 1'b0;
        err_nx   = 1'b0;
        if (clear) begin
            data_nx  = '0;
            cnt_nx   = '0;
            state_nx = ENTRY;
        end else if (commit) begin
            if (state == ENTRY && count != 4'd0) begin
                value_nx = data_out;
                cv_nx    = 1'b1;
                state_nx = LOCKED;
            end else begin
                err_nx = 1'b1;
            end
        end else if (backspace) begin
            if (state == ENTRY && count != 4'd0) begin
                data_nx = {4'h0, data_out[31:4]};
                cnt_nx  = count - 4'd1;
            end else begin
                err_nx = 1'b1;
            end
        end else if (digit_valid) begin
            if (state == ENTRY && digit_in <= 4'd9 && count < MAXC) begin
                data_nx = {data_out[27:0], digit_in} & KEEP;
                cnt_nx  = count + 4'd1;
            end else begin
                err_nx = 1'b1;
            end
        end
    end

    // Display word is built from next-state data so it lines up with data_out.
    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            digit_disp_lane #(.BLANK_CODE(BLANK_CODE)) u_lane (
                .digit   (data_nx[4*i +: 4]),
                .entered (4'(i) < cnt_nx),
                .mask    (mask_w),
                .disp    (disp_nx[i])
            );
        end
    endgenerate

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ENTRY;
            data_out     <= '0;
            disp_out     <= {NUM_LANES{BLANK_CODE}};
            count        <= '0;
            value_out    <= '0;
            commit_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nx;
            data_out     <= data_nx;
            disp_out     <= disp_nx;
            count        <= cnt_nx;
            value_out    <= value_nx;
            commit_valid <= cv_nx;
            err          <= err_nx;
        end
    end

    assign full   = (count == MAXC);
    assign empty  = (count == 4'd0);
    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_digit_entry_packer.sv
// Scoreboard bench for digit_entry_packer: stimulus pushes hand-computed
// expected outputs, a monitor pops and compares one entry per clock.
module tb_digit_entry_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        digit_valid, backspace, clear, commit;
    logic [3:0]  digit_in;
    logic [31:0] data_out, disp_out, value_out;
    logic [3:0]  count;
    logic        full, empty, locked, commit_valid, err;
`ifdef DIGIT_MASK_EN
    logic        mask = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [31:0] disp;
        logic [3:0]  cnt;
        logic        lck;
        logic [31:0] val;
        logic        cv;
        logic        er;
    } exp_t;
    exp_t q[$];
    int   step_id = 0;

    digit_entry_packer #(.MAX_DIGITS(8), .BLANK_CODE(4'hF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit_valid  (digit_valid),
        .digit_in     (digit_in),
        .backspace    (backspace),
        .clear        (clear),
        .commit       (commit),
`ifdef DIGIT_MASK_EN
        .mask         (mask),
`endif
        .data_out     (data_out),
        .disp_out     (disp_out),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .locked       (locked),
        .value_out    (value_out),
        .commit_valid (commit_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " data"},  data_out, 32'h0);
        chk({tag, " disp"},  disp_out, 32'hFFFF_FFFF);
        chk({tag, " count"}, 32'(count), 32'd0);
        chk({tag, " empty"}, 32'(empty), 32'd1);
        chk({tag, " full"},  32'(full), 32'd0);
        chk({tag, " locked"}, 32'(locked), 32'd0);
        chk({tag, " value"}, value_out, 32'h0);
        chk({tag, " cv"},    32'(commit_valid), 32'd0);
        chk({tag, " err"},   32'(err), 32'd0);
    endtask

    // Drive one cycle of strobes and queue the expected post-edge outputs.
    task automatic step(input logic dv, input logic [3:0] din, input logic bs,
                        input logic cl, input logic cm,
                        input logic [31:0] ed, input logic [31:0] edisp,
                        input logic [3:0] ec, input logic el,
                        input logic [31:0] ev, input logic ecv, input logic eer);
        exp_t e;
        @(negedge clk);
        digit_valid = dv; digit_in = din; backspace = bs; clear = cl; commit = cm;
        step_id++;
        e.id = step_id; e.data = ed; e.disp = edisp; e.cnt = ec; e.lck = el;
        e.val = ev; e.cv = ecv; e.er = eer;
        q.push_back(e);
    endtask

    // Monitor: compare every registered output one step after each stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("s%0d data", e.id),   data_out, e.data);
                chk($sformatf("s%0d disp", e.id),   disp_out, e.disp);
                chk($sformatf("s%0d count", e.id),  32'(count), 32'(e.cnt));
                chk($sformatf("s%0d full", e.id),   32'(full), 32'(e.cnt == 4'd8));
                chk($sformatf("s%0d empty", e.id),  32'(empty), 32'(e.cnt == 4'd0));
                chk($sformatf("s%0d locked", e.id), 32'(locked), 32'(e.lck));
                chk($sformatf("s%0d value", e.id),  value_out, e.val);
                chk($sformatf("s%0d cv", e.id),     32'(commit_valid), 32'(e.cv));
                chk($sformatf("s%0d err", e.id),    32'(err), 32'(e.er));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        digit_valid = 0; digit_in = 0; backspace = 0; clear = 0; commit = 0;
        repeat (2) @(negedge clk);
        #1 check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 1..8, then a 9th digit is rejected.
        step(1, 4'd1, 0, 0, 0, 32'h0000_0001, 32'hFFFF_FFF1, 1, 0, 0, 0, 0);
        step(1, 4'd2, 0, 0, 0, 32'h0000_0012, 32'hFFFF_FF12, 2, 0, 0, 0, 0);
        step(1, 4'd3, 0, 0, 0, 32'h0000_0123, 32'hFFFF_F123, 3, 0, 0, 0, 0);
        step(1, 4'd4, 0, 0, 0, 32'h0000_1234, 32'hFFFF_1234, 4, 0, 0, 0, 0);
        step(1, 4'd5, 0, 0, 0, 32'h0001_2345, 32'hFFF1_2345, 5, 0, 0, 0, 0);
        step(1, 4'd6, 0, 0, 0, 32'h0012_3456, 32'hFF12_3456, 6, 0, 0, 0, 0);
        step(1, 4'd7, 0, 0, 0, 32'h0123_4567, 32'hF123_4567, 7, 0, 0, 0, 0);
        step(1, 4'd8, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 8, 0, 0, 0, 0);
        step(1, 4'd9, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 8, 0, 0, 0, 1);
        step(0, 4'd0, 0, 0, 0, 32'h1234_5678, 32'h1234_5678, 8, 0, 0, 0, 0);
        step(0, 4'd0, 0, 1, 0, 32'h0,         32'hFFFF_FFFF, 0, 0, 0, 0, 0);

        // Backspace, illegal digit, backspace past empty, commit when empty.
        step(1, 4'd1, 0, 0, 0, 32'h0000_0001, 32'hFFFF_FFF1, 1, 0, 0, 0, 0);
        step(1, 4'd2, 0, 0, 0, 32'h0000_0012, 32'hFFFF_FF12, 2, 0, 0, 0, 0);
        step(1, 4'd3, 0, 0, 0, 32'h0000_0123, 32'hFFFF_F123, 3, 0, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0, 32'h0000_0012, 32'hFFFF_FF12, 2, 0, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0, 32'h0000_0001, 32'hFFFF_FFF1, 1, 0, 0, 0, 0);
        step(1, 4'hB, 0, 0, 0, 32'h0000_0001, 32'hFFFF_FFF1, 1, 0, 0, 0, 1);
        step(0, 4'd0, 1, 0, 0, 32'h0,         32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        step(0, 4'd0, 1, 0, 0, 32'h0,         32'hFFFF_FFFF, 0, 0, 0, 0, 1);
        step(0, 4'd0, 0, 0, 1, 32'h0,         32'hFFFF_FFFF, 0, 0, 0, 0, 1);

        // Commit 42, edits rejected while locked, clear unlocks.
        step(1, 4'd4, 0, 0, 0, 32'h0000_0004, 32'hFFFF_FFF4, 1, 0, 0, 0, 0);
        step(1, 4'd2, 0, 0, 0, 32'h0000_0042, 32'hFFFF_FF42, 2, 0, 0, 0, 0);
        step(0, 4'd0, 0, 0, 1, 32'h0000_0042, 32'hFFFF_FF42, 2, 1, 32'h42, 1, 0);
        step(0, 4'd0, 0, 0, 0, 32'h0000_0042, 32'hFFFF_FF42, 2, 1, 32'h42, 0, 0);
        step(1, 4'd7, 0, 0, 0, 32'h0000_0042, 32'hFFFF_FF42, 2, 1, 32'h42, 0, 1);
        step(0, 4'd0, 1, 0, 0, 32'h0000_0042, 32'hFFFF_FF42, 2, 1, 32'h42, 0, 1);
        step(0, 4'd0, 0, 0, 1, 32'h0000_0042, 32'hFFFF_FF42, 2, 1, 32'h42, 0, 1);
        step(0, 4'd0, 0, 1, 0, 32'h0,         32'hFFFF_FFFF, 0, 0, 32'h42, 0, 0);

        // Same-cycle strobes: clear wins, then commit wins over edits.
        step(1, 4'd5, 0, 0, 0, 32'h0000_0005, 32'hFFFF_FFF5, 1, 0, 32'h42, 0, 0);
        step(1, 4'd6, 0, 0, 0, 32'h0000_0056, 32'hFFFF_FF56, 2, 0, 32'h42, 0, 0);
        step(1, 4'd7, 0, 0, 0, 32'h0000_0567, 32'hFFFF_F567, 3, 0, 32'h42, 0, 0);
        step(1, 4'd1, 0, 1, 1, 32'h0,         32'hFFFF_FFFF, 0, 0, 32'h42, 0, 0);
        step(1, 4'd3, 0, 0, 0, 32'h0000_0003, 32'hFFFF_FFF3, 1, 0, 32'h42, 0, 0);
        step(1, 4'd4, 1, 0, 1, 32'h0000_0003, 32'hFFFF_FFF3, 1, 1, 32'h3,  1, 0);
        step(0, 4'd0, 0, 1, 0, 32'h0,         32'hFFFF_FFFF, 0, 0, 32'h3,  0, 0);

        // Async reset right after a commit pulse.
        step(1, 4'd1, 0, 0, 0, 32'h0000_0001, 32'hFFFF_FFF1, 1, 0, 32'h3,  0, 0);
        step(1, 4'd2, 0, 0, 0, 32'h0000_0012, 32'hFFFF_FF12, 2, 0, 32'h3,  0, 0);
        step(0, 4'd0, 0, 0, 1, 32'h0000_0012, 32'hFFFF_FF12, 2, 1, 32'h12, 1, 0);
        @(negedge clk);
        digit_valid = 0; digit_in = 0; backspace = 0; clear = 0; commit = 0;
        rst_n = 1'b0;
        #1 check_reset("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 4'd0, 0, 0, 0, 32'h0,         32'hFFFF_FFFF, 0, 0, 32'h0,  0, 0);

`ifdef DIGIT_MASK_EN
        mask = 1'b1;
        step(1, 4'd9, 0, 0, 0, 32'h0000_0009, 32'hFFFF_FFFA, 1, 0, 32'h0,  0, 0);
        step(1, 4'd8, 0, 0, 0, 32'h0000_0098, 32'hFFFF_FFAA, 2, 0, 32'h0,  0, 0);
`endif
        step(0, 4'd0, 0, 0, 0, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0,  0, 0)
            ;
        // Leave the last entry for the monitor, then make sure it drained.
        repeat (3) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
